// File: rtl/viterbi_pkg.sv
// Shared definitions for the convolutional encoder and the Viterbi decoder:
// default code parameters, the symbol type, the FSM state type and the
// parity function that both sides use to compute code symbols.
package viterbi_pkg;

   localparam int         K_DEF  = 7;
   localparam logic [6:0] G0_DEF = 7'o171;
   localparam logic [6:0] G1_DEF = 7'o133;

   localparam int         MAX_K  = 9;

   typedef logic [1:0] sym_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENC   = 2'd1,
      FLUSH = 2'd2
   } encState_e;

   // Bit 0 is the G0 parity and bit 1 the G1 parity. The window and the
   // polynomials are zero-extended to MAX_K, so one function serves every K.
   function automatic sym_t conv_sym(input logic [MAX_K-1:0] window,
                                     input logic [MAX_K-1:0] g0,
                                     input logic [MAX_K-1:0] g1);
      return {^(window & g1), ^(window & g0)};
   endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Streaming handshake bundle for the convolutional encoder: the information
// bit stream going in and the 2-bit code symbol stream coming out.
interface conv_encoder_if;
   import viterbi_pkg::*;

   logic in_valid;
   logic in_ready;
   logic in_bit;
   logic in_last;
   logic out_valid;
   logic out_ready;
   sym_t out_sym;
   logic out_last;

   modport slave (
      input  in_valid, in_bit, in_last, out_ready,
      output in_ready, out_valid, out_sym, out_last
   );

   modport master (
      output in_valid, in_bit, in_last, out_ready,
      input  in_ready, out_valid, out_sym, out_last
   );

endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 feedforward convolutional encoder with a single output register
// stage and optional zero-tail termination, so that every terminated frame
// leaves the trellis in state 0.
module conv_encoder
   import viterbi_pkg::*;
#(
   parameter int         K    = K_DEF,
   parameter logic [K-1:0] G0 = K'(G0_DEF),
   parameter logic [K-1:0] G1 = K'(G1_DEF),
   parameter bit         TAIL = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   conv_encoder_if.slave  bus,
   output logic           busy
);

   localparam int TCW = $clog2(K);

   encState_e      state;
   logic [K-2:0]   sr;
   logic [TCW-1:0] tailCnt;
   logic           started;
   logic           outValid;
   sym_t           outSym;
   logic           outLast;

   logic           canLoad;
   logic           inFire;
   logic           tailStep;
   logic           bitNow;
   logic [K-1:0]   window;
   logic [K-2:0]   nextSr;
   sym_t           symNow;

   // The output register may take a new symbol when it is empty or when its
   // current symbol leaves this cycle; both data input and tail symbols pace
   // on this, and a FLUSH in progress blocks new data bits.
   always_comb begin
      canLoad  = !outValid || bus.out_ready;
      inFire   = bus.in_valid && started && (state != FLUSH) && canLoad;
      tailStep = (state == FLUSH) && canLoad;
      bitNow   = (state == FLUSH) ? 1'b0 : bus.in_bit;
      window   = {bitNow, sr};
      nextSr   = window[K-1:1];
      symNow   = conv_sym(MAX_K'(window), MAX_K'(G0), MAX_K'(G1));
   end

   assign bus.in_ready  = started && (state != FLUSH) && canLoad;
   assign bus.out_valid = outValid;
   assign bus.out_sym   = outSym;
   assign bus.out_last  = outLast;
   assign busy          = (state != IDLE);

   // Holds in_ready low while reset is asserted and opens the input port from
   // the first clock edge after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started <= 1'b0;
      end else begin
         started <= 1'b1;
      end
   end

   // Frame FSM, shift register, tail counter and output register. An accepted
   // data bit or a tail step reloads the output register in the same edge that
   // the previous symbol is taken, so there is no bubble; otherwise a taken
   // symbol simply empties the register, and a stalled one is held untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sr       <= '0;
         tailCnt  <= '0;
         outValid <= 1'b0;
         outSym   <= '0;
         outLast  <= 1'b0;
      end else if (inFire) begin
         outValid <= 1'b1;
         outSym   <= symNow;
         if (!bus.in_last) begin
            state   <= ENC;
            sr      <= nextSr;
            outLast <= 1'b0;
         end else if (TAIL) begin
            state   <= FLUSH;
            sr      <= nextSr;
            tailCnt <= '0;
            outLast <= 1'b0;
         end else begin
            state   <= IDLE;
            sr      <= '0;
            outLast <= 1'b1;
         end
      end else if (tailStep) begin
         outValid <= 1'b1;
         outSym   <= symNow;
         sr       <= nextSr;
         if (tailCnt == TCW'(K-2)) begin
            state   <= IDLE;
            tailCnt <= '0;
            outLast <= 1'b1;
         end else begin
            tailCnt <= tailCnt + 1'b1;
            outLast <= 1'b0;
         end
      end else if (bus.out_ready) begin
         outValid <= 1'b0;
         outLast  <= 1'b0;
      end
   end

endmodule
